sseg_scan_driver: RTL and testbench
===================================

Name: sseg_scan_driver

Overview:
- Downstream consumer of the sequence FSM's digit values: drives a 4-digit common-anode 7-segment display by time-multiplexing one digit at a time.
- Latches a 16-bit value (four hex nibbles), decodes each nibble to active-low cathodes and scans the anodes.
- Inserts a blanking gap between digits to suppress ghosting. Display updates are frame-synchronous, so a frame never shows torn data.

Parameters:
- REFRESH_DIV, 100000, clk cycles per digit slot (1 kHz per digit at 100 MHz); must be > BLANK_CYCLES.
- BLANK_CYCLES, 2000, cycles at start of each slot with all anodes off; 0 = no blank phase.

Ports:
- clk  in  1  system clock (100 MHz)
- RST  in  1  synchronous active-high reset
- data_in  in  16  digit values; [3:0] = digit 0 (rightmost) … [15:12] = digit 3
- load  in  1  1-cycle strobe; captures data_in and dp_in into pending registers
- dp_in  in  4  decimal-point request per digit, active-high
- digit_en  in  4  per-digit enable, live (not latched); 0 = digit dark during its slot
- state_reg  out  7  cathodes, active-low, bit6 = a … bit0 = g
- dp_n  out  1  decimal-point cathode, active-low
- Anode_Activate  out  4  anodes, active-low, bit0 = rightmost
- frame_tick  out  1  1-cycle pulse when the active registers are updated (frame start)

Behaviour:
- Reset is synchronous, on posedge clk with RST=1:
  - dig_idx=0, slot_cnt=0, FSM=BLANK.
  - pending and active data, and pending and active dp, cleared to 0.
  - Anode_Activate=4'b1111, state_reg=7'b1111111, dp_n=1, frame_tick=0.
- RST mid-frame discards any pending load.
- All outputs are registered and reflect the FSM state of the current cycle.
- slot_cnt runs 0..REFRESH_DIV-1 and wraps.
- FSM:
  - BLANK (slot_cnt < BLANK_CYCLES): Anode_Activate=1111, state_reg=1111111, dp_n=1.
  - SHOW (remaining cycles): anode bit dig_idx low only if digit_en[dig_idx]=1.
    - state_reg = decode(active nibble dig_idx).
    - dp_n = ~active_dp[dig_idx].
- BLANK→SHOW when slot_cnt reaches BLANK_CYCLES.
- SHOW→BLANK when slot_cnt wraps. On that wrap, dig_idx increments mod 4.
- Frame boundary (dig_idx wraps 3→0):
  - active ← pending; frame_tick=1 for that cycle.
  - If load=1 in the same cycle, active ← data_in/dp_in directly (bypass), and pending is also updated.
- A load outside a boundary updates pending only; the displayed value changes at the next frame start.
- Multiple loads within a frame: last one wins.
- With BLANK_CYCLES=0 the FSM stays in SHOW, and anodes switch directly between digits at the wrap.
- Digit 0 keeps a 1-slot offset: the first frame after reset shows 0000 (blank data latched at reset).
- Decode table (hex→state_reg):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000

Optional Feature:
- Macro: SSEG_LZ_SUPPRESS_EN.
- Defined: leading-zero suppression on active data. Digit k (k=3..1) is blanked during SHOW (anode held high, cathodes 1111111) when its nibble and all higher nibbles are 0. Digit 0 is never suppressed; dp on a suppressed digit is also suppressed.
  - Example: 16'h0070 shows only digits 1 and 0.
- Undefined: every enabled digit is shown, including leading zeros.

Test Plan:
- Reset: RST high 2 cycles → Anode_Activate=1111, state_reg=1111111, dp_n=1, frame_tick=0. Then with REFRESH_DIV=8, BLANK_CYCLES=2, digit_en=1111: first SHOW at cycle 2 after reset release, anode 1110, state_reg=0000001.
- Scan order and timing (REFRESH_DIV=8, BLANK_CYCLES=2): load 16'h7010, dp_in=0 → after frame_tick, anodes cycle 1110,1101,1011,0111.
  - Each digit has 2 blank + 6 show cycles.
  - Cathodes are 0000001, 1001111, 0000001, 0001111.
  - frame_tick repeats every 32 cycles.
- Frame-synchronous update: load 16'h1111 mid-frame while 16'h7010 is active → digits keep the old data until the next frame_tick, then all show 1001111. Load at the exact boundary cycle → new data appears in that same frame.
- digit_en=0101 with dp_in=0001, data 16'hFFFF → only anodes 1110 and 1011 are ever asserted; dp_n=0 only in digit 0's SHOW phase; slot timing is unchanged.
- Reset mid-SHOW on digit 2 after load → next cycle all outputs off, dig_idx=0, pending load discarded.
- With SSEG_LZ_SUPPRESS_EN, load 16'h0000 → only digit 0 lights (0000001); load 16'h0100 → digits 2, 1 and 0 light, digit 3 stays dark.

Source files
------------

// File: rtl/sseg_scan_if.sv
// Display-side bundle for sseg_scan_driver: value/strobe/enable inputs plus
// the cathode, anode and frame-tick outputs that drive the display.
interface sseg_scan_if;
  logic [15:0] data_in;
  logic        load;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic [6:0]  state_reg;
  logic        dp_n;
  logic [3:0]  Anode_Activate;
  logic        frame_tick;

  modport master (
    output data_in, load, dp_in, digit_en,
    input  state_reg, dp_n, Anode_Activate, frame_tick
  );

  modport slave (
    input  data_in, load, dp_in, digit_en,
    output state_reg, dp_n, Anode_Activate, frame_tick
  );
endinterface

// File: rtl/sseg_scan_driver.sv
// Time-multiplexed 4-digit common-anode 7-segment driver with per-slot blanking
// and frame-synchronous data update. Define SSEG_LZ_SUPPRESS_EN for leading-zero suppression.
module sseg_scan_driver #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 2000
) (
  input  logic       clk,
  input  logic       RST,
  sseg_scan_if.slave bus
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic {BLANK, SHOW} scan_state_t;

  scan_state_t      state, state_nxt;
  logic [CNT_W-1:0] slot_cnt, slot_nxt;
  logic [1:0]       dig_idx, dig_nxt;
  logic             slot_wrap, frame_start;
  logic [15:0]      pend_data, pend_data_nxt, act_data, act_data_nxt;
  logic [3:0]       pend_dp, pend_dp_nxt, act_dp, act_dp_nxt;
  logic [3:0]       nib;
  logic             lz_blank;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  // Outputs are built from next-cycle values so they agree with the state registers.
  always_comb begin
    slot_wrap   = (slot_cnt == CNT_W'(REFRESH_DIV - 1));
    slot_nxt    = slot_wrap ? '0 : slot_cnt + CNT_W'(1);
    dig_nxt     = slot_wrap ? dig_idx + 2'd1 : dig_idx;
    frame_start = slot_wrap && (dig_idx == 2'd3);

    pend_data_nxt = bus.load ? bus.data_in : pend_data;
    pend_dp_nxt   = bus.load ? bus.dp_in   : pend_dp;
    act_data_nxt  = frame_start ? pend_data_nxt : act_data;
    act_dp_nxt    = frame_start ? pend_dp_nxt   : act_dp;
    nib           = act_data_nxt[{dig_nxt, 2'b00} +: 4];

    state_nxt = state;
    case (state)
      BLANK: if (slot_nxt >= CNT_W'(BLANK_CYCLES)) state_nxt = SHOW;
      SHOW:  if (slot_wrap && (BLANK_CYCLES != 0)) state_nxt = BLANK;
      default: state_nxt = BLANK;
    endcase
  end

`ifdef SSEG_LZ_SUPPRESS_EN
  always_comb begin
    case (dig_nxt)
      2'd3:    lz_blank = (act_data_nxt[15:12] == 4'h0);
      2'd2:    lz_blank = (act_data_nxt[15:8]  == 8'h0);
      2'd1:    lz_blank = (act_data_nxt[15:4]  == 12'h0);
      default: lz_blank = 1'b0;
    endcase
  end
`else
  assign lz_blank = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (RST) begin
      slot_cnt           <= '0;
      dig_idx            <= '0;
      state              <= BLANK;
      pend_data          <= '0;
      pend_dp            <= '0;
      act_data           <= '0;
      act_dp             <= '0;
      bus.Anode_Activate <= 4'b1111;
      bus.state_reg      <= 7'b1111111;
      bus.dp_n           <= 1'b1;
      bus.frame_tick     <= 1'b0;
    end else begin
      slot_cnt       <= slot_nxt;
      dig_idx        <= dig_nxt;
      state          <= state_nxt;
      pend_data      <= pend_data_nxt;
      pend_dp        <= pend_dp_nxt;
      act_data       <= act_data_nxt;
      act_dp         <= act_dp_nxt;
      bus.frame_tick <= frame_start;
      // A disabled digit keeps its cathodes driven; only the anode stays off.
      if ((state_nxt == SHOW) && !lz_blank) begin
        bus.state_reg      <= seg_decode(nib);
        bus.dp_n           <= ~act_dp_nxt[dig_nxt];
        bus.Anode_Activate <= bus.digit_en[dig_nxt] ? ~(4'b0001 << dig_nxt) : 4'b1111;
      end else begin
        bus.state_reg      <= 7'b1111111;
        bus.dp_n           <= 1'b1;
        bus.Anode_Activate <= 4'b1111;
      end
    end
  end

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Self-checking bench for sseg_scan_driver (REFRESH_DIV=8, BLANK_CYCLES=2):
// timeline model plus directed literal checks.
module tb_sseg_scan_driver;

  localparam int R = 8;
  localparam int B = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  sseg_scan_if bus();

  sseg_scan_driver #(.REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
    .clk (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model state: time since reset release drives slot/digit/phase arithmetically.
  int          m_t  = 0;
  logic        m_live = 1'b0;
  logic [15:0] m_pend = 16'h0, m_act = 16'h0;
  logic [3:0]  m_pdp = 4'h0, m_adp = 4'h0;
  logic [3:0]  e_anode = 4'hF;
  logic [6:0]  e_seg = 7'h7F;
  logic        e_dp = 1'b1, e_tick = 1'b0;

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    logic [6:0] tab [16];
    tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
            7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
            7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
            7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    return tab[v];
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0d, time %0t)", name, act, exp, m_t, $time);
    end
  endtask

  task automatic model_step();
    int   dig;
    logic on;
    if (rst) begin
      m_t = 0; m_pend = 16'h0; m_act = 16'h0; m_pdp = 4'h0; m_adp = 4'h0;
      e_tick = 1'b0; m_live = 1'b1;
    end else begin
      m_t++;
      if (bus.load) begin m_pend = bus.data_in; m_pdp = bus.dp_in; end
      e_tick = ((m_t % (4 * R)) == 0);
      if (e_tick) begin m_act = m_pend; m_adp = m_pdp; end
    end
    dig = (m_t / R) % 4;
    on  = !rst && ((m_t % R) >= B);
`ifdef SSEG_LZ_SUPPRESS_EN
    if (dig != 0 && (m_act >> (4 * dig)) == 16'h0) on = 1'b0;
`endif
    if (on) begin
      e_seg   = seg_of(m_act[4*dig +: 4]);
      e_dp    = ~m_adp[dig];
      e_anode = bus.digit_en[dig] ? ~(4'b0001 << dig) : 4'b1111;
    end else begin
      e_seg = 7'h7F; e_dp = 1'b1; e_anode = 4'hF;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (m_live) begin
      check("anode", int'(bus.Anode_Activate), int'(e_anode));
      check("seg",   int'(bus.state_reg),      int'(e_seg));
      check("dp_n",  int'(bus.dp_n),           int'(e_dp));
      check("tick",  int'(bus.frame_tick),     int'(e_tick));
    end
  end

  task automatic wait_t(input int k);
    int n;
    n = 0;
    while (m_t != k && n < 2000) begin @(negedge clk); n++; end
    if (m_t != k) check("wait_t_timeout", m_t, k);
  endtask

  task automatic load_val(input logic [15:0] d, input logic [3:0] dp);
    bus.data_in = d; bus.dp_in = dp; bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  initial begin
    bus.data_in = 16'h0; bus.dp_in = 4'h0; bus.load = 1'b0; bus.digit_en = 4'b1111;
    repeat (2) @(negedge clk);
    check("rst_anode", int'(bus.Anode_Activate), 'hF);
    check("rst_seg",   int'(bus.state_reg),      'h7F);
    check("rst_dp",    int'(bus.dp_n),           1);
    check("rst_tick",  int'(bus.frame_tick),     0);
    rst = 1'b0;

    wait_t(1);
    check("first_blank", int'(bus.Anode_Activate), 'hF);
    wait_t(2);
    check("first_show_anode", int'(bus.Anode_Activate), 'b1110);
    check("first_show_seg",   int'(bus.state_reg),      'b0000001);

    // Scan order with 7010
    wait_t(3);
    load_val(16'h7010, 4'h0);
    wait_t(31);
    check("tick_pre", int'(bus.frame_tick), 0);
    wait_t(32);
    check("tick_frame", int'(bus.frame_tick), 1);
    wait_t(34); check("d0_anode", int'(bus.Anode_Activate), 'b1110); check("d0_seg", int'(bus.state_reg), 'b0000001);
    wait_t(42); check("d1_anode", int'(bus.Anode_Activate), 'b1101); check("d1_seg", int'(bus.state_reg), 'b1001111);
    wait_t(47); check("d1_last",  int'(bus.Anode_Activate), 'b1101);
    wait_t(48); check("d2_blank", int'(bus.Anode_Activate), 'hF);
    wait_t(50); check("d2_anode", int'(bus.Anode_Activate), 'b1011); check("d2_seg", int'(bus.state_reg), 'b0000001);
    wait_t(58); check("d3_anode", int'(bus.Anode_Activate), 'b0111); check("d3_seg", int'(bus.state_reg), 'b0001111);
    wait_t(64); check("tick_period", int'(bus.frame_tick), 1);

    // Mid-frame load is deferred to the next frame
    wait_t(70);
    load_val(16'h1111, 4'h0);
    wait_t(90);  check("old_d3_seg", int'(bus.state_reg), 'b0001111);
    wait_t(122); check("new_d3_seg", int'(bus.state_reg), 'b1001111);

    // Load sampled on the frame-boundary edge goes straight to active
    wait_t(127);
    load_val(16'h2345, 4'h0);
    wait_t(130); check("bypass_d0", int'(bus.state_reg), 'b0100100);
    wait_t(138); check("bypass_d1", int'(bus.state_reg), 'b1001100);

    // digit_en and decimal point
    wait_t(140);
    load_val(16'hFFFF, 4'b0001);
    wait_t(159);
    bus.digit_en = 4'b0101;
    wait_t(162); check("en_d0_anode", int'(bus.Anode_Activate), 'b1110);
                 check("en_d0_dp",    int'(bus.dp_n), 0);
                 check("en_d0_seg",   int'(bus.state_reg), 'b0111000);
    wait_t(170); check("en_d1_anode", int'(bus.Anode_Activate), 'hF);
                 check("en_d1_dp",    int'(bus.dp_n), 1);
    wait_t(178); check("en_d2_anode", int'(bus.Anode_Activate), 'b1011);
                 check("en_d2_dp",    int'(bus.dp_n), 1);
    wait_t(186); check("en_d3_anode", int'(bus.Anode_Activate), 'hF);

    // Reset mid-SHOW on digit 2 discards the pending load
    wait_t(192);
    bus.digit_en = 4'b1111;
    wait_t(195);
    load_val(16'hABCD, 4'hF);
    wait_t(212);
    check("pre_rst_anode", int'(bus.Anode_Activate), 'b1011);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_anode", int'(bus.Anode_Activate), 'hF);
    check("mid_rst_seg",   int'(bus.state_reg),      'h7F);
    check("mid_rst_dp",    int'(bus.dp_n),           1);
    wait_t(2);  check("post_rst_anode", int'(bus.Anode_Activate), 'b1110);
    wait_t(32); check("post_rst_tick",  int'(bus.frame_tick), 1);
    wait_t(34); check("discard_seg",    int'(bus.state_reg), 'b0000001);
                check("discard_dp",     int'(bus.dp_n), 1);
`ifdef SSEG_LZ_SUPPRESS_EN
    wait_t(42); check("zero_d1_anode", int'(bus.Anode_Activate), 'hF);
`else
    wait_t(42); check("zero_d1_anode", int'(bus.Anode_Activate), 'b1101);
`endif

    // 0100: digit 3 is a leading zero
    wait_t(43);
    load_val(16'h0100, 4'h0);
    wait_t(74); check("h0100_d1_anode", int'(bus.Anode_Activate), 'b1101);
    wait_t(82); check("h0100_d2_seg",   int'(bus.state_reg), 'b1001111);
                check("h0100_d2_anode", int'(bus.Anode_Activate), 'b1011);
`ifdef SSEG_LZ_SUPPRESS_EN
    wait_t(90); check("h0100_d3_anode", int'(bus.Anode_Activate), 'hF);
                check("h0100_d3_seg",   int'(bus.state_reg), 'h7F);
`else
    wait_t(90); check("h0100_d3_anode", int'(bus.Anode_Activate), 'b0111);
                check("h0100_d3_seg",   int'(bus.state_reg), 'b0000001);
`endif
    wait_t(100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
